// File: rtl/dmac_chsched.sv
// DMA channel scheduler: arbitrates pending channel requests onto one
// shared transfer engine, with a RUN-state watchdog per grant.
module dmac_chsched #(
  parameter int NCH = 4,
  parameter int SW  = 2,
  parameter int TMO = 65535
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] en,
  input  logic           prio_mode,
  input  logic           eng_busy,
  input  logic           eng_done,
  output logic           eng_start,
  output logic [SW-1:0]  sel,
  output logic           active,
  output logic [NCH-1:0] pend,
  output logic [NCH-1:0] ch_done,
  output logic [NCH-1:0] ch_err
);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    START,
    RUN,
    FIN
  } state_t;

  localparam logic [15:0] TLAST = 16'(TMO - 1);

  state_t         state;
  logic [SW-1:0]  rr_ptr;
  logic [SW-1:0]  win;
  logic           hit;
  logic [15:0]    cnt;
  logic [NCH-1:0] grant_clr;
  logic [NCH-1:0] pend_nxt;
  logic [NCH-1:0] sel_oh;

  // Search order starts at rr_ptr (round-robin) or at 0 (fixed).
  always_comb begin
    logic [SW-1:0] idx;
    win = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = prio_mode ? SW'(k) : rr_ptr + SW'(k);
      if (!hit && pend[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end

  always_comb begin
    grant_clr = '0;
    if (state == ARB && hit) begin
      grant_clr = NCH'(1) << win;
    end
  end

  // A fresh request in the granting cycle keeps the channel pending.
  assign pend_nxt  = en & ((pend & ~grant_clr) | req);
  assign sel_oh    = NCH'(1) << sel;
  assign eng_start = (state == START) && !eng_busy;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= IDLE;
      pend    <= '0;
      sel     <= '0;
      rr_ptr  <= '0;
      cnt     <= '0;
      active  <= 1'b0;
      ch_done <= '0;
      ch_err  <= '0;
    end else begin
      pend    <= pend_nxt;
      ch_done <= '0;
      ch_err  <= '0;
      unique case (state)
        IDLE: begin
          if (|pend) state <= ARB;
        end
        ARB: begin
          if (hit) begin
            sel    <= win;
            active <= 1'b1;
            state  <= START;
          end else begin
            state <= IDLE;
          end
        end
        START: begin
          if (!eng_busy) begin
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (eng_done) begin
            ch_done <= sel_oh;
            state   <= FIN;
          end else if (cnt == TLAST) begin
            ch_err <= sel_oh;
            active <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        FIN: begin
          rr_ptr <= sel + SW'(1);
          active <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmac_chsched.sv
// Scoreboard bench for dmac_chsched: expected grants, completions and
// timeouts are queued as stimulus is driven and checked as they appear.
module tb_dmac_chsched;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] en = '0;
  logic       prio_mode = 1'b0;
  logic       eng_busy = 1'b0;
  logic       eng_done = 1'b0;
  logic       eng_start;
  logic [1:0] sel;
  logic       active;
  logic [3:0] pend;
  logic [3:0] ch_done;
  logic [3:0] ch_err;

  int nchk = 0;
  int nfail = 0;

  int         gq[$];
  logic [3:0] dq[$];
  logic [3:0] eq[$];

  dmac_chsched #(.NCH(4), .SW(2), .TMO(8)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req       (req),
    .en        (en),
    .prio_mode (prio_mode),
    .eng_busy  (eng_busy),
    .eng_done  (eng_done),
    .eng_start (eng_start),
    .sel       (sel),
    .active    (active),
    .pend      (pend),
    .ch_done   (ch_done),
    .ch_err    (ch_err)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (eng_start) begin
        if (gq.size() == 0) chk("grant_extra", 32'(eng_start), 0);
        else chk("grant_sel", 32'(sel), gq.pop_front());
      end
      if (ch_done != '0) begin
        chk("done_1hot", 32'($onehot(ch_done)), 1);
        if (dq.size() == 0) chk("done_extra", 32'(ch_done), 0);
        else chk("done_vec", 32'(ch_done), 32'(dq.pop_front()));
      end
      if (ch_err != '0) begin
        chk("err_1hot", 32'($onehot(ch_err)), 1);
        if (eq.size() == 0) chk("err_extra", 32'(ch_err), 0);
        else chk("err_vec", 32'(ch_err), 32'(eq.pop_front()));
      end
    end
  end

  task automatic do_reset();
    HRESETn = 1'b0;
    req = '0;
    en = '0;
    prio_mode = 1'b0;
    eng_busy = 1'b0;
    eng_done = 1'b0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic wait_start();
    int n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!eng_start && n < 40);
    if (!eng_start) chk("start_tmo", 32'(eng_start), 1);
  endtask

  task automatic fin(input int ch, input int dly);
    repeat (dly) @(posedge HCLK);
    #1 eng_done = 1'b1;
    dq.push_back(4'(1 << ch));
    @(posedge HCLK);
    #1 eng_done = 1'b0;
  endtask

  task automatic q_empty(input string tag);
    chk(tag, 32'(gq.size() + dq.size() + eq.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1 HRESETn = 1'b0;
    #1;
    chk("rst_pend", 32'(pend), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_start", 32'(eng_start), 0);
    chk("rst_done", 32'(ch_done), 0);
    chk("rst_err", 32'(ch_err), 0);

    // Single request: latency to eng_start and completion timing.
    do_reset();
    en = 4'b1111;
    req = 4'b0001;
    gq.push_back(0);
    tick(1);
    req = '0;
    @(negedge HCLK);
    chk("lat_c1", 32'(eng_start), 0);
    chk("pend_set", 32'(pend), 32'h1);
    @(negedge HCLK);
    chk("lat_c2", 32'(eng_start), 0);
    @(negedge HCLK);
    chk("lat_c3", 32'(eng_start), 1);
    chk("pend_clr", 32'(pend), 0);
    chk("act_start", 32'(active), 1);
    fin(0, 5);
    @(negedge HCLK);
    chk("act_fin", 32'(active), 1);
    tick(1);
    // rr_ptr is now 1, so channel 1 wins over channel 0.
    req = 4'b0011;
    gq.push_back(1);
    gq.push_back(0);
    tick(1);
    req = '0;
    wait_start();
    fin(1, 2);
    wait_start();
    fin(0, 2);
    tick(4);
    q_empty("q_t1");

    // Round-robin with all channels held pending.
    do_reset();
    en = 4'b1111;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) gq.push_back(i % 4);
    for (int i = 0; i < 5; i++) begin
      wait_start();
      fin(i % 4, 2);
    end
    req = '0;
    en = '0;
    tick(8);
    q_empty("q_rr");

    // Fixed priority: late request on channel 0 jumps ahead of 3.
    do_reset();
    en = 4'b1111;
    prio_mode = 1'b1;
    req = 4'b1010;
    gq.push_back(1);
    tick(1);
    req = '0;
    wait_start();
    tick(1);
    req = 4'b0001;
    gq.push_back(0);
    gq.push_back(3);
    tick(1);
    req = '0;
    fin(1, 1);
    wait_start();
    fin(0, 2);
    wait_start();
    fin(3, 2);
    tick(6);
    q_empty("q_prio");

    // Engine busy holds START without a start pulse.
    do_reset();
    en = 4'b1111;
    eng_busy = 1'b1;
    req = 4'b0100;
    gq.push_back(2);
    tick(1);
    req = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge HCLK);
      chk("busy_hold", 32'(eng_start), 0);
      tick(1);
    end
    chk("busy_act", 32'(active), 1);
    eng_busy = 1'b0;
    @(negedge HCLK);
    chk("busy_go", 32'(eng_start), 1);
    @(negedge HCLK);
    chk("busy_once", 32'(eng_start), 0);
    tick(0);
    fin(2, 2);
    tick(4);
    q_empty("q_busy");

    // Watchdog timeout after 8 RUN cycles.
    do_reset();
    en = 4'b1111;
    req = 4'b1000;
    gq.push_back(3);
    tick(1);
    req = '0;
    wait_start();
    eq.push_back(4'b1000);
    for (int c = 1; c <= 8; c++) begin
      @(negedge HCLK);
      chk("tmo_wait", 32'(ch_err), 0);
      chk("tmo_act", 32'(active), 1);
    end
    @(negedge HCLK);
    chk("tmo_idle", 32'(active), 0);
    tick(4);
    q_empty("q_tmo");

    // Disabling a pending channel drops it; it is never granted.
    do_reset();
    en = 4'b1111;
    req = 4'b0100;
    tick(1);
    en = 4'b1011;
    @(negedge HCLK);
    chk("en_pend1", 32'(pend), 32'h4);
    @(negedge HCLK);
    chk("en_pend0", 32'(pend), 0);
    tick(5);
    chk("en_hold", 32'(pend), 0);
    req = 4'b0110;
    gq.push_back(1);
    tick(1);
    req = '0;
    wait_start();
    fin(1, 2);
    tick(4);
    chk("en_final", 32'(pend), 0);
    q_empty("q_en");

    // Asynchronous reset in RUN abandons the grant silently.
    en = 4'b1111;
    req = 4'b1000;
    gq.push_back(3);
    tick(1);
    req = '0;
    wait_start();
    tick(1);
    chk("run_active", 32'(active), 1);
    #2 HRESETn = 1'b0;
    #1;
    chk("ar_active", 32'(active), 0);
    chk("ar_sel", 32'(sel), 0);
    chk("ar_start", 32'(eng_start), 0);
    chk("ar_pend", 32'(pend), 0);
    chk("ar_done", 32'(ch_done), 0);
    chk("ar_err", 32'(ch_err), 0);
    tick(2);
    HRESETn = 1'b1;
    eng_done = 1'b1;
    tick(1);
    eng_done = 1'b0;
    tick(12);
    chk("ar_idle", 32'(active), 0);
    q_empty("q_end");

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
